// File: rtl/mul_div_seq.sv
// mul_div_seq: iterative unsigned MULTU/DIVU sequencer producing HI/LO.
// It owns no adder. Each step drives one shared external N-bit adder
// (Cin = 0, add only) and consumes its sum at the next clock edge.
// Ports:
//   i_clk, i_rst_n    rising-edge clock, synchronous active-low reset
//   i_start, i_op     start request (IDLE only); 0 = MULTU, 1 = DIVU
//   i_a, i_b          multiplicand/dividend, multiplier/divisor
//   o_add_a, o_add_b  operands to the shared adder (decoded from registers)
//   i_add_sum         sum returned by the shared adder
//   o_busy, o_done    busy in NEG/ITER; one-cycle completion pulse
//   o_hi, o_lo        high product/remainder, low product/quotient
//   o_div_by_zero     set by a DIVU with zero divisor, cleared on next start
module mul_div_seq #(
  parameter int unsigned N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic         i_op,
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_add_a,
  output logic [N-1:0] o_add_b,
  input  logic [N-1:0] i_add_sum,
  output logic         o_busy,
  output logic         o_done,
  output logic [N-1:0] o_hi,
  output logic [N-1:0] o_lo,
  output logic         o_div_by_zero
);

  localparam int unsigned CW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NEG  = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t         r_state;
  logic           r_op;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_acc;   // P_hi for multiply, R for divide
  logic [N-1:0]   r_low;   // P_lo for multiply, Q for divide
  logic [N-1:0]   r_opnd;  // M for multiply, D then -D for divide

  logic           w_carry;
  logic           w_ge;
  logic           w_last;
  logic [N-1:0]   w_t;
  logic [N-1:0]   w_nxt_hi;
  logic [N-1:0]   w_nxt_lo;

  // Carry-out rebuilt from operand and sum MSBs since the adder exposes none.
  assign w_carry = (o_add_a[N-1] & o_add_b[N-1]) |
                   ((o_add_a[N-1] | o_add_b[N-1]) & ~i_add_sum[N-1]);

  // Divide: shifted partial remainder; the bit shifted out of R means T >= D.
  assign w_t    = {r_acc[N-2:0], r_low[N-1]};
  assign w_ge   = r_acc[N-1] | w_carry;
  assign w_last = (r_cnt == CW'(N - 1));

  // Result of the current ITER step for either operation.
  always_comb begin
    w_nxt_hi = {w_carry, i_add_sum[N-1:1]};
    w_nxt_lo = {i_add_sum[0], r_low[N-1:1]};
    if (r_op) begin
      w_nxt_hi = w_ge ? i_add_sum : w_t;
      w_nxt_lo = {r_low[N-2:0], w_ge};
    end
  end

  // Adder operands are a pure decode of registered state so the sum settles
  // within the cycle and is captured at the next edge.
  always_comb begin
    o_add_a = '0;
    o_add_b = '0;
    case (r_state)
      S_NEG: begin
        o_add_a = N'(1);
        o_add_b = ~r_opnd;
      end
      S_ITER: begin
        if (r_op) begin
          o_add_a = w_t;
          o_add_b = r_opnd;
        end else begin
          o_add_a = r_acc;
          o_add_b = r_low[0] ? r_opnd : '0;
        end
      end
      default: ;
    endcase
  end

  // Sequencer state, datapath registers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_op          <= 1'b0;
      r_cnt         <= '0;
      r_acc         <= '0;
      r_low         <= '0;
      r_opnd        <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_hi          <= '0;
      o_lo          <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            o_div_by_zero <= 1'b0;
            r_op          <= i_op;
            r_cnt         <= '0;
            r_acc         <= '0;
            r_low         <= i_a;
            r_opnd        <= i_b;
            if (!i_op) begin
              o_busy  <= 1'b1;
              r_state <= S_ITER;
            end else if (i_b != '0) begin
              o_busy  <= 1'b1;
              r_state <= S_NEG;
            end else begin
              o_hi          <= i_a;
              o_lo          <= '1;
              o_div_by_zero <= 1'b1;
              o_done        <= 1'b1;
              r_state       <= S_DONE;
            end
          end
        end
        S_NEG: begin
          r_opnd  <= i_add_sum;
          r_cnt   <= '0;
          r_state <= S_ITER;
        end
        S_ITER: begin
          r_acc <= w_nxt_hi;
          r_low <= w_nxt_lo;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            o_hi    <= w_nxt_hi;
            o_lo    <= w_nxt_lo;
            o_busy  <= 1'b0;
            o_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_seq.sv
// tb_mul_div_seq: randomized bench for mul_div_seq with an arithmetic
// reference model, per-cycle output monitor and literal directed cases.
module tb_mul_div_seq;

  localparam int unsigned N = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [N-1:0] add_a, add_b, add_sum, hi, lo;
  logic         busy, done, dbz;

  // Shared external adder: plain N-bit add, carry discarded.
  assign add_sum = add_a + add_b;

  always #5 clk = ~clk;

  mul_div_seq #(.N(N)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
    .i_a(a), .i_b(b), .o_add_a(add_a), .o_add_b(add_b),
    .i_add_sum(add_sum), .o_busy(busy), .o_done(done),
    .o_hi(hi), .o_lo(lo), .o_div_by_zero(dbz)
  );

  int n_total = 0;
  int n_bad   = 0;

  function automatic void chk(string nm, logic [63:0] got, logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endfunction

  typedef struct {
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         dbz;
  } res_t;

  // Reference: MULTU/DIVU results from plain unsigned arithmetic.
  function automatic res_t model(bit mop, logic [N-1:0] ma, logic [N-1:0] mb);
    res_t r;
    logic [63:0] p;
    r.dbz = 1'b0;
    if (!mop) begin
      p = {32'b0, ma} * {32'b0, mb};
      r.hi = p[63:32];
      r.lo = p[31:0];
    end else if (mb == '0) begin
      r.hi  = ma;
      r.lo  = '1;
      r.dbz = 1'b1;
    end else begin
      r.hi = ma % mb;
      r.lo = ma / mb;
    end
    return r;
  endfunction

  res_t         exp_q[$];
  logic [N-1:0] m_hi = '0;
  logic [N-1:0] m_lo = '0;
  logic         m_dbz = 1'b0;
  bit           mon_en = 1'b0;
  res_t         mon_e;

  // Per-cycle compare: results only change on Done, adder idle when not busy.
  always @(negedge clk) begin
    if (mon_en) begin
      if (done) begin
        chk("busy_with_done", 64'(busy), 64'(0));
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'(1), 64'(0));
        end else begin
          mon_e = exp_q.pop_front();
          m_hi  = mon_e.hi;
          m_lo  = mon_e.lo;
          m_dbz = mon_e.dbz;
        end
      end
      chk("mon_hi", 64'(hi), 64'(m_hi));
      chk("mon_lo", 64'(lo), 64'(m_lo));
      chk("mon_dbz", 64'(dbz), 64'(m_dbz));
      if (!busy) begin
        chk("idle_add_a", 64'(add_a), 64'(0));
        chk("idle_add_b", 64'(add_b), 64'(0));
      end
    end
  end

  // Issue one operation and wait (bounded) for its Done pulse.
  task automatic run_op(input bit op_i, input logic [N-1:0] a_i,
                        input logic [N-1:0] b_i, input bit inject,
                        output logic [N-1:0] r_hi, output logic [N-1:0] r_lo,
                        output logic r_dbz);
    res_t e;
    int   lat, bcnt, exp_lat;
    e = model(op_i, a_i, b_i);
    exp_lat = !op_i ? int'(N) + 1 : (b_i == '0 ? 1 : int'(N) + 2);
    r_hi = 'x; r_lo = 'x; r_dbz = 1'bx;
    @(posedge clk); #1;
    start = 1'b1; op = op_i; a = a_i; b = b_i;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    exp_q.push_back(e);
    m_dbz = 1'b0;
    lat = 0; bcnt = 0;
    for (int c = 1; c <= int'(N) + 8; c++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (done) begin
        lat = c; r_hi = hi; r_lo = lo; r_dbz = dbz;
        break;
      end
      if (inject && (c == 5 || c == 20)) begin
        start = 1'b1; op = 1'($urandom); a = $urandom; b = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (lat == 0) chk("done_timeout", 64'(0), 64'(1));
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("busy_cycles", 64'(bcnt), 64'(exp_lat - 1));
  endtask

  logic [N-1:0] r_hi, r_lo;
  logic         r_dbz;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_dbz", 64'(dbz), 64'(0));
    chk("rst_add", {add_a, add_b}, 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, r_hi, r_lo, r_dbz);
    chk("mul_max_hi", 64'(r_hi), 64'h0000_0000_FFFF_FFFE);
    chk("mul_max_lo", 64'(r_lo), 64'h0000_0000_0000_0001);

    run_op(1'b1, 32'd100, 32'd7, 1'b0, r_hi, r_lo, r_dbz);
    chk("div_100_7_hi", 64'(r_hi), 64'd2);
    chk("div_100_7_lo", 64'(r_lo), 64'd14);

    run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, r_hi, r_lo, r_dbz);
    chk("div_max_1_hi", 64'(r_hi), 64'd0);
    chk("div_max_1_lo", 64'(r_lo), 64'h0000_0000_FFFF_FFFF);

    run_op(1'b1, 32'h1234_5678, 32'd0, 1'b0, r_hi, r_lo, r_dbz);
    chk("div0_hi", 64'(r_hi), 64'h0000_0000_1234_5678);
    chk("div0_lo", 64'(r_lo), 64'h0000_0000_FFFF_FFFF);
    chk("div0_flag", 64'(r_dbz), 64'd1);

    run_op(1'b0, 32'd3, 32'd5, 1'b0, r_hi, r_lo, r_dbz);
    chk("mul_3_5_hi", 64'(r_hi), 64'd0);
    chk("mul_3_5_lo", 64'(r_lo), 64'd15);
    chk("mul_3_5_dbz", 64'(r_dbz), 64'd0);

    run_op(1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1, r_hi, r_lo, r_dbz);
    chk("mul_inject_hi", 64'(r_hi), 64'd1);
    chk("mul_inject_lo", 64'(r_lo), 64'd0);

    // Reset in the middle of a DIVU aborts it with no Done.
    @(posedge clk); #1;
    start = 1'b1; op = 1'b1; a = 32'd1000; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    mon_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("pre_rst_done", 64'(done), 64'(0));
    @(negedge clk);
    chk("mid_rst_out", {hi, lo}, 64'(0));
    chk("mid_rst_flags", 64'({busy, done, dbz}), 64'(0));
    chk("mid_rst_add", {add_a, add_b}, 64'(0));
    exp_q.delete();
    m_hi = '0; m_lo = '0; m_dbz = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_done", 64'(done), 64'(0));

    run_op(1'b0, 32'd6, 32'd7, 1'b0, r_hi, r_lo, r_dbz);
    chk("mul_6_7_lo", 64'(r_lo), 64'd42);
    chk("mul_6_7_hi", 64'(r_hi), 64'd0);

    // Randomized operations; the monitor compares every Done against the model.
    for (int i = 0; i < 1000; i++) begin
      logic [N-1:0] ra, rb;
      bit           rop;
      rop = 1'($urandom);
      ra  = $urandom;
      rb  = $urandom;
      if ($urandom_range(0, 3) == 0) rb = N'($urandom_range(1, 255));
      if ($urandom_range(0, 7) == 0) ra = N'($urandom_range(0, 1000));
      if ($urandom_range(0, 19) == 0) rb = '0;
      run_op(rop, ra, rb, 1'b0, r_hi, r_lo, r_dbz);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
